// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt key-schedule datapath.
//   - Memory layout defaults (P-array offset/size, S-box size).
//   - expand_state_t: sequencer states of expand_state.
//   - Helpers that pick the salt words mixed into a block.
package bcrypt_pkg;

  localparam int P_ARRAY_OFFSET = 4000;
  localparam int P_WORDS        = 18;
  localparam int S_WORDS        = 1024;
  localparam int IDX_W          = 11;  // holds word indices 0..1041
  localparam int ADDR_W         = 12;  // SRAM word address

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MIX    = 3'd1,
    FIRE   = 3'd2,
    WAIT   = 3'd3,
    WR_L   = 3'd4,
    WR_R   = 3'd5,
    FINISH = 3'd6
  } expand_state_t;

  // Salt word XORed into L for the block starting at word_idx.
  // Block k = word_idx/2 uses words 2k mod 4 (L) and 2k+1 mod 4 (R).
  function automatic logic [1:0] salt_word_idx(input logic [IDX_W-1:0] word_idx);
    logic [IDX_W-1:0] k;
    k = word_idx >> 1;
    return 2'((k % 2) * 2);
  endfunction

  // word0 is the most significant 32 bits of the salt.
  function automatic logic [31:0] salt_word(input logic [127:0] salt,
                                            input logic [1:0]   w);
    logic [31:0] r;
    case (w)
      2'd0:    r = salt[127:96];
      2'd1:    r = salt[95:64];
      2'd2:    r = salt[63:32];
      default: r = salt[31:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/expand_addr_map.sv
// Combinational map from key-schedule word index to SRAM word address.
//   word_idx_i : word index 0..P_WORDS+S_WORDS-1
//   addr_o     : P_ARRAY_OFFSET+i for the P-array, i-P_WORDS for S-boxes
module expand_addr_map
  import bcrypt_pkg::*;
#(
  parameter int P_OFFSET = P_ARRAY_OFFSET,
  parameter int P_COUNT  = P_WORDS
) (
  input  logic [IDX_W-1:0]  word_idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] P_BASE = ADDR_W'(P_OFFSET);
  localparam logic [IDX_W-1:0]  P_LIM  = IDX_W'(P_COUNT);

  logic [ADDR_W-1:0] idx_ext;
  assign idx_ext = {{(ADDR_W-IDX_W){1'b0}}, word_idx_i};

  always_comb begin
    if (word_idx_i < P_LIM) addr_o = P_BASE + idx_ext;
    else                    addr_o = idx_ext - ADDR_W'(P_COUNT);
  end

endmodule

// File: rtl/expand_state.sv
// bcrypt ExpandState / ExpandKey sequencer.
// Encrypts a chained (L,R) pair through the external feistel block, optionally
// salting it first, and writes each result over the P-array then the S-boxes.
//   clk, reset          : clock, synchronous active-high reset
//   start, salted, salt : pass request, salt enable (sampled on start), salt
//   busy, done          : pass in progress, one-cycle completion pulse
//   f_start, f_L, f_R   : request to feistel
//   f_resultL/R, f_done : response from feistel
//   sram_grant          : this block owns both SRAM write ports
//   wr_addr/data/cs_l/we_l : SRAM write port (active-low strobes)
//   dbg_state           : current sequencer state, for observation only
//
// Handshake: feistel is fired by a single-cycle f_start with f_L/f_R valid in
// that cycle; they stay stable until the single-cycle f_done, whose results
// are valid in the same cycle. f_done outside WAIT is ignored, as is start
// outside IDLE.
module expand_state
  import bcrypt_pkg::*;
#(
  parameter int P_ARRAY_OFFSET = bcrypt_pkg::P_ARRAY_OFFSET,
  parameter int P_WORDS        = bcrypt_pkg::P_WORDS,
  parameter int S_WORDS        = bcrypt_pkg::S_WORDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         salted,
  input  logic [127:0] salt,
  output logic         busy,
  output logic         done,
  output logic         f_start,
  output logic [31:0]  f_L,
  output logic [31:0]  f_R,
  input  logic [31:0]  f_resultL,
  input  logic [31:0]  f_resultR,
  input  logic         f_done,
  output logic         sram_grant,
  output logic [11:0]  wr_addr,
  output logic [31:0]  wr_data,
  output logic         wr_cs_l,
  output logic         wr_we_l,
  output logic [2:0]   dbg_state
);

  // Index of the first word of the final block.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_WORDS + S_WORDS - 2);

  expand_state_t    state_q, state_d;
  logic [31:0]      l_q, l_d, r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             salted_q, salted_d;
  logic [1:0]       sw_l;
  logic [IDX_W-1:0] map_idx;
  logic [11:0]      map_addr;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      l_q      <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      salted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      salted_q <= salted_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MIX;
      MIX:     state_d = FIRE;
      FIRE:    state_d = WAIT;
      WAIT:    if (f_done) state_d = WR_L;
      WR_L:    state_d = WR_R;
      WR_R:    state_d = (idx_q == LAST_IDX) ? FINISH : MIX;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  assign sw_l = salt_word_idx(idx_q);

  always_comb begin
    l_d      = l_q;
    r_d      = r_q;
    idx_d    = idx_q;
    salted_d = salted_q;
    case (state_q)
      IDLE: if (start) begin
        salted_d = salted;
        l_d      = '0;
        r_d      = '0;
        idx_d    = '0;
      end
      MIX: if (salted_q) begin
        l_d = l_q ^ salt_word(salt, sw_l);
        r_d = r_q ^ salt_word(salt, sw_l | 2'd1);
      end
      WAIT: if (f_done) begin
        l_d = f_resultL;
        r_d = f_resultR;
      end
      WR_R: if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(2);
      default: ;
    endcase
  end

  // WR_R writes the second word of the pair.
  assign map_idx = (state_q == WR_R) ? idx_q + IDX_W'(1) : idx_q;

  expand_addr_map #(
    .P_OFFSET (P_ARRAY_OFFSET),
    .P_COUNT  (P_WORDS)
  ) u_addr_map (
    .word_idx_i (map_idx),
    .addr_o     (map_addr)
  );

  // Outputs
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    f_start    = 1'b0;
    sram_grant = 1'b0;
    wr_cs_l    = 1'b1;
    wr_we_l    = 1'b1;
    wr_addr    = '0;
    wr_data    = '0;
    case (state_q)
      MIX, WAIT: busy = 1'b1;
      FIRE: begin
        busy    = 1'b1;
        f_start = 1'b1;
      end
      WR_L, WR_R: begin
        busy       = 1'b1;
        sram_grant = 1'b1;
        wr_cs_l    = 1'b0;
        wr_we_l    = 1'b0;
        wr_addr    = map_addr;
        wr_data    = (state_q == WR_L) ? l_q : r_q;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign f_L       = l_q;
  assign f_R       = r_q;
  assign dbg_state = state_q;

endmodule
